// File: rtl/rotate_validator.sv
// rotate_validator: holds the active piece and commits a proposed rotation only when all four
// candidate tiles are inside the playfield and unoccupied on the board RAM.
module rotate_validator #(
    parameter int COLS = 10,
    parameter int ROWS = 20,
    parameter int X_W  = 4,
    parameter int Y_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [4*X_W-1:0] load_x,
    input  logic [4*Y_W-1:0] load_y,
    input  logic             start,
    input  logic [4*X_W-1:0] prop_x,
    input  logic [4*Y_W-1:0] prop_y,
    output logic             rd_en,
    output logic [X_W-1:0]   rd_x,
    output logic [Y_W-1:0]   rd_y,
    input  logic             rd_data,
    output logic             busy,
    output logic             done,
    output logic             accepted,
    output logic [4*X_W-1:0] cur_x,
    output logic [4*Y_W-1:0] cur_y
);
    typedef enum logic [1:0] {IDLE, CHECK, LAST} state_t;
    localparam logic [X_W:0] COLS_L = (X_W+1)'(COLS);
    localparam logic [Y_W:0] ROWS_L = (Y_W+1)'(ROWS);
    state_t             state;
    logic [1:0]         idx, nidx;
    logic [4*X_W-1:0]   px;
    logic [4*Y_W-1:0]   py;
    logic               fail, rd_q, hit, pass, n_ok, s_ok;
    logic [X_W-1:0]     nx, sx;
    logic [Y_W-1:0]     ny, sy;

    function automatic logic in_bounds(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return ({1'b0, x} < COLS_L) && ({1'b0, y} < ROWS_L);
    endfunction

    // rd_q remembers whether last cycle issued a read, so rd_data is only trusted for real reads
    always_comb begin
        nidx = idx + 2'd1;
        nx = px[nidx*X_W +: X_W];
        ny = py[nidx*Y_W +: Y_W];
        sx = prop_x[X_W-1:0];
        sy = prop_y[Y_W-1:0];
        n_ok = in_bounds(nx, ny);
        s_ok = in_bounds(sx, sy);
        hit = rd_q && rd_data && (idx != 2'd0);
        pass = !(fail || hit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= 2'd0;
            px       <= '0;
            py       <= '0;
            fail     <= 1'b0;
            rd_q     <= 1'b0;
            rd_en    <= 1'b0;
            rd_x     <= '0;
            rd_y     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            accepted <= 1'b0;
            cur_x    <= '0;
            cur_y    <= '0;
        end else begin
            done <= 1'b0;
            rd_q <= rd_en;
            case (state)
                IDLE: begin
                    if (load) begin
                        cur_x <= load_x;
                        cur_y <= load_y;
                    end else if (start) begin
                        px    <= prop_x;
                        py    <= prop_y;
                        idx   <= 2'd0;
                        state <= CHECK;
                        busy  <= 1'b1;
                        rd_en <= s_ok;
                        fail  <= !s_ok;
                        if (s_ok) begin
                            rd_x <= sx;
                            rd_y <= sy;
                        end
                    end
                end
                CHECK: begin
                    if (idx == 2'd3) begin
                        rd_en <= 1'b0;
                        fail  <= !pass;
                        state <= LAST;
                    end else begin
                        idx   <= nidx;
                        rd_en <= n_ok;
                        fail  <= !pass || !n_ok;
                        if (n_ok) begin
                            rd_x <= nx;
                            rd_y <= ny;
                        end
                    end
                end
                LAST: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    accepted <= pass;
                    if (pass) begin
                        cur_x <= px;
                        cur_y <= py;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rotate_validator.sv
// tb_rotate_validator: randomized and directed stimulus with a queue scoreboard; a board
// occupancy array serves both as the RAM model and as the legality reference.
module tb_rotate_validator;
    localparam int COLS = 10;
    localparam int ROWS = 20;

    logic        clk = 1'b0;
    logic        rst_n, load, start, rd_data, rd_en, busy, done, accepted;
    logic [15:0] load_x, prop_x, cur_x;
    logic [19:0] load_y, prop_y, cur_y;
    logic [3:0]  rd_x;
    logic [4:0]  rd_y;

    int  cyc = 0, checks = 0, errors = 0, m_done_edge = 0;
    bit  fin = 1'b0;
    bit  occ [32][16];
    logic [15:0] m_cx = '0, e_cx = '0;
    logic [19:0] m_cy = '0, e_cy = '0;
    logic        e_acc = 1'b0;

    typedef struct {int en; bit acc; logic [15:0] cx; logic [19:0] cy;} res_t;
    typedef struct {int en; logic [3:0] x; logic [4:0] y;} rd_t;
    typedef struct {int en; logic [15:0] cx; logic [19:0] cy;} ld_t;
    res_t resq[$];
    rd_t  rdq[$];
    ld_t  ldq[$];

    rotate_validator dut (
        .clk(clk), .rst_n(rst_n), .load(load), .load_x(load_x), .load_y(load_y),
        .start(start), .prop_x(prop_x), .prop_y(prop_y), .rd_en(rd_en), .rd_x(rd_x),
        .rd_y(rd_y), .rd_data(rd_data), .busy(busy), .done(done), .accepted(accepted),
        .cur_x(cur_x), .cur_y(cur_y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // unread cycles return noise so a design trusting stale rd_data is exposed
    always @(posedge clk) rd_data <= rd_en ? occ[rd_y][rd_x] : 1'($urandom);

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    always @(negedge clk) begin
        res_t r;
        rd_t  q;
        ld_t  l;
        if (cyc > 0) begin
            if (!rst_n) begin
                resq.delete();
                rdq.delete();
                ldq.delete();
                e_cx = '0;
                e_cy = '0;
                e_acc = 1'b0;
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_rd_en", 32'(rd_en), 0);
                chk("rst_cur_x", 32'(cur_x), 0);
                chk("rst_cur_y", 32'(cur_y), 0);
            end else begin
                while (ldq.size() > 0 && ldq[0].en <= cyc) begin
                    l = ldq.pop_front();
                    e_cx = l.cx;
                    e_cy = l.cy;
                end
                if (rd_en) begin
                    chk("rd_expected", 32'(rdq.size() > 0), 1);
                    if (rdq.size() > 0) begin
                        q = rdq.pop_front();
                        chk("rd_cycle", cyc, q.en);
                        chk("rd_x", 32'(rd_x), 32'(q.x));
                        chk("rd_y", 32'(rd_y), 32'(q.y));
                    end
                end
                if (done) begin
                    chk("done_expected", 32'(resq.size() > 0), 1);
                    if (resq.size() > 0) begin
                        r = resq.pop_front();
                        chk("done_cycle", cyc, r.en);
                        e_acc = r.acc;
                        e_cx = r.cx;
                        e_cy = r.cy;
                    end
                end
                chk("busy", 32'(busy), 32'(resq.size() > 0));
                chk("accepted", 32'(accepted), 32'(e_acc));
                chk("cur_x", 32'(cur_x), 32'(e_cx));
                chk("cur_y", 32'(cur_y), 32'(e_cy));
                if (fin) begin
                    chk("results_drained", resq.size(), 0);
                    chk("reads_drained", rdq.size(), 0);
                    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                    $finish;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] px, input logic [19:0] py);
        bit ok;
        int e;
        logic [3:0] x;
        logic [4:0] y;
        prop_x = px;
        prop_y = py;
        start = 1'b1;
        tick();
        start = 1'b0;
        prop_x = 16'($urandom);
        prop_y = 20'($urandom);
        e = cyc;
        if (e > m_done_edge) begin
            ok = 1'b1;
            for (int i = 0; i < 4; i++) begin
                x = px[i*4 +: 4];
                y = py[i*5 +: 5];
                if (x >= COLS || y >= ROWS) ok = 1'b0;
                else begin
                    rdq.push_back(rd_t'{e + i, x, y});
                    if (occ[y][x]) ok = 1'b0;
                end
            end
            if (ok) begin
                m_cx = px;
                m_cy = py;
            end
            resq.push_back(res_t'{e + 5, ok, m_cx, m_cy});
            m_done_edge = e + 5;
        end
    endtask

    task automatic do_load(input logic [15:0] lx, input logic [19:0] ly, input bit s);
        load_x = lx;
        load_y = ly;
        load = 1'b1;
        start = s;
        prop_x = {4'd6, 4'd5, 4'd4, 4'd3};
        prop_y = {4{5'd1}};
        tick();
        load = 1'b0;
        start = 1'b0;
        if (cyc > m_done_edge) begin
            m_cx = lx;
            m_cy = ly;
            ldq.push_back(ld_t'{cyc, lx, ly});
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_done_edge = 0;
        m_cx = '0;
        m_cy = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic clear_board();
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 16; x++) occ[y][x] = 1'b0;
    endtask

    localparam logic [15:0] SPAWN_X = {4'd4, 4'd4, 4'd4, 4'd4};
    localparam logic [19:0] SPAWN_Y = {5'd3, 5'd2, 5'd1, 5'd0};
    localparam logic [15:0] ROT_X   = {4'd6, 4'd5, 4'd4, 4'd3};
    localparam logic [19:0] ROT_Y   = {5'd1, 5'd1, 5'd1, 5'd1};

    initial begin
        logic [3:0] bx;
        logic [4:0] by;
        logic [15:0] px;
        logic [19:0] py;
        clear_board();
        rst_n = 1'b0;
        load = 1'b1;
        start = 1'b1;
        load_x = 16'hFFFF;
        load_y = 20'hFFFFF;
        prop_x = ROT_X;
        prop_y = ROT_Y;
        repeat (3) tick();
        load = 1'b0;
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();
        // accept on an empty board
        do_load(SPAWN_X, SPAWN_Y, 1'b0);
        do_start(ROT_X, ROT_Y);
        repeat (7) tick();
        // collision at (5,1)
        do_load(SPAWN_X, SPAWN_Y, 1'b0);
        occ[1][5] = 1'b1;
        do_start(ROT_X, ROT_Y);
        repeat (7) tick();
        clear_board();
        // wrapped x on tile0, then y=ROWS on tile3
        do_start({4'd6, 4'd5, 4'd4, 4'd15}, ROT_Y);
        repeat (7) tick();
        do_start(ROT_X, {5'd20, 5'd1, 5'd1, 5'd1});
        repeat (7) tick();
        // start and load while busy are ignored
        do_start(ROT_X, ROT_Y);
        tick();
        do_start({4'd7, 4'd6, 4'd5, 4'd4}, ROT_Y);
        do_load(16'h1234, 20'h54321, 1'b0);
        repeat (7) tick();
        do_load(SPAWN_X, SPAWN_Y, 1'b1);
        repeat (7) tick();
        // reset in the middle of a check
        do_start(ROT_X, ROT_Y);
        tick();
        do_reset();
        do_load(SPAWN_X, SPAWN_Y, 1'b0);
        do_start(ROT_X, ROT_Y);
        repeat (7) tick();
        for (int n = 0; n < 80; n++) begin
            if (cyc >= m_done_edge && $urandom_range(0, 3) == 0)
                for (int y = 0; y < ROWS; y++)
                    for (int x = 0; x < COLS; x++) occ[y][x] = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 4))
                0: do_load(16'($urandom), 20'($urandom), 1'($urandom));
                default: begin
                    bx = 4'($urandom_range(0, 10));
                    by = 5'($urandom_range(0, 20));
                    for (int i = 0; i < 4; i++) begin
                        px[i*4 +: 4] = bx + 4'($urandom_range(0, 2)) - 4'd1;
                        py[i*5 +: 5] = by + 5'($urandom_range(0, 2)) - 5'd1;
                    end
                    do_start(px, py);
                end
            endcase
            repeat ($urandom_range(0, 7)) tick();
        end
        repeat (8) tick();
        fin = 1'b1;
    end
endmodule

// File: doc/rotate_validator.md
Name: rotate_validator

Overview:
Owns the active falling piece's four tile coordinates and commits a proposed rotation only if it is legal. The shape rotator computes candidate coordinates combinationally. This block then checks each candidate tile against the playfield bounds and the board occupancy RAM, one read per cycle. It then commits the candidate (accept) or keeps the current piece (reject). The board RAM holds only locked tiles, never the active piece.

Parameters:
COLS, 10, playfield width in tiles
ROWS, 20, playfield height in tiles
X_W, 4, x coordinate width
Y_W, 5, y coordinate width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
load  in  1  one-cycle pulse: spawn piece from load_x/load_y
load_x  in  4*X_W  {t3,t2,t1,t0} x of spawned tiles
load_y  in  4*Y_W  {t3,t2,t1,t0} y of spawned tiles
start  in  1  one-cycle pulse: validate prop_x/prop_y
prop_x  in  4*X_W  {t3..t0} proposed x (rotator output)
prop_y  in  4*Y_W  {t3..t0} proposed y (rotator output)
rd_en  out  1  board RAM read strobe
rd_x  out  X_W  board RAM read column
rd_y  out  Y_W  board RAM read row
rd_data  in  1  occupancy; valid the cycle after rd_en (synchronous RAM)
busy  out  1  validation in progress
done  out  1  one-cycle pulse: result valid
accepted  out  1  result of the last validation; held until next done
cur_x  out  4*X_W  committed piece x {t3..t0}
cur_y  out  4*Y_W  committed piece y {t3..t0}

Behaviour:
- Reset (async, rst_n=0): state=IDLE. busy, done, accepted, rd_en=0. rd_x, rd_y, cur_x, cur_y, latched proposal and fail flag=0.
- FSM states are IDLE, CHECK (idx 0..3) and LAST.
- IDLE:
  - load=1: cur_x/cur_y <= load_x/load_y at this edge; done and accepted unchanged.
  - Else start=1: latch prop_x/prop_y, clear fail, idx=0, go to CHECK, busy=1.
  - load and start in the same cycle: load wins, start dropped.
- CHECK: each cycle handles latched tile[idx].
  - In bounds (x<COLS and y<ROWS, unsigned compare): drive rd_en=1, rd_x/rd_y=tile coords.
  - Out of bounds: rd_en=0 and set fail. Underflowed coordinates (0-1 wraps to 15 or 31) are therefore caught as out of bounds.
  - Each cycle with idx>0, if the previous cycle's rd_en=1 and rd_data=1, set fail.
  - idx=3 goes to LAST; otherwise idx+1.
- LAST: rd_en=0. Sample rd_data for tile 3 (same rule). Return to IDLE. At this edge register done=1, accepted=!fail, busy=0. If accepted, cur_x/cur_y <= latched proposal.
- Latency and timing:
  - Edge N: start sampled.
  - Cycles N+1..N+4: rd_en as per bounds.
  - Edge N+5: done high for exactly one cycle; cur updated on the same edge.
  - Latency is fixed regardless of early failure.
- done deasserts the next cycle. accepted holds until the next done.
- start or load while busy: ignored. No queuing.
- Proposal inputs may change after the start cycle; only the latched copy is used.
- Reset asserted mid-CHECK: immediate abort to reset values. No done pulse. cur_x/cur_y return to 0.
- All outputs are registered. rd_x/rd_y hold their last value when rd_en=0.

Test Plan:
1. Reset: hold rst_n=0 with start=1 and load=1 -> busy, done, rd_en=0 and cur_x/cur_y=0. After release, one idle cycle -> no state change.
2. Accept, empty board: load x={4,4,4,4}, y={3,2,1,0}; start with prop x={6,5,4,3}, y={1,1,1,1}.
   - rd_en high 4 cycles, addresses (3,1),(4,1),(5,1),(6,1).
   - done 5 edges after start, accepted=1, cur_x={6,5,4,3}, cur_y={1,1,1,1}.
3. Collision: same as 2, but RAM returns 1 for (5,1) -> accepted=0, cur unchanged ({4,4,4,4}/{3,2,1,0}), done still at 5 edges.
4. Out of bounds: prop tile0 x=15 (wrapped), others legal -> rd_en=0 in the tile0 cycle, accepted=0, cur unchanged. Also prop tile3 y=20 -> rejected.
5. Protocol edge cases:
   - start pulsed again at N+2 -> ignored, only one done.
   - load at N+3 -> ignored, cur unchanged by the load.
   - load+start together in IDLE -> cur loads, busy stays 0, no done.
6. Reset mid-op: rst_n=0 at N+2 -> busy, rd_en=0 immediately. No done ever appears. Next start after release behaves as scenario 2.
